// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory bus arbiter.
//   size_e      : MEM32 access size codes as driven on m_size / mem_c
//   state_e     : arbiter FSM states
//   size_align_err() : flags reserved sizes and accesses not aligned to their size
package mem_bus_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } state_e;

    function automatic logic size_align_err(input size_e size, input logic [1:0] addr_lo);
        logic err;
        err = 1'b0;
        case (size)
            SZ_BYTE: err = 1'b0;
            SZ_HALF: err = addr_lo[0];
            SZ_WORD: err = |addr_lo;
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i, scanning upward with wrap.
//   req_i   : request vector
//   ptr_i   : index with highest priority this round
//   grant_o : one-hot grant (all zero when nothing requests)
//   idx_o   : index of the granted requester
//   valid_o : some requester was granted
module rr_arbiter #(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    always_comb begin
        int unsigned      cand;
        logic [IDX_W-1:0] cand_idx;
        logic             found;
        grant_o  = '0;
        idx_o    = '0;
        cand     = 0;
        cand_idx = '0;
        found    = 1'b0;
        for (int unsigned off = 0; off < N; off++) begin
            // ptr_i < N, so a single subtraction is enough to wrap
            cand = 32'(ptr_i) + off;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = IDX_W'(cand);
            if (!found && req_i[cand_idx]) begin
                found             = 1'b1;
                grant_o[cand_idx] = 1'b1;
                idx_o             = cand_idx;
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter putting N masters onto one MEM32-style memory port.
// Each transaction: IDLE (grant + check), ACCESS (WAIT_CYC+1 strobe cycles), RESP; the
// ack/err pulse is registered and so appears in the cycle after RESP.
//   clk_in, reset            : clock, asynchronous active-high reset
//   m_req/m_we/m_size/m_sign : per-master request, direction, size code, sign-extend flag
//   m_addr/m_wdata           : per-master byte address and write data (packed, master 0 lowest)
//   m_ack/m_err/m_rdata      : one-cycle completion, error flag, shared read data
//   mem_w/mem_r              : memory strobes, high only during ACCESS
//   mem_c/mem_s/mem_addr/mem_wdata : latched size, sign, rebased address, write data
//   mem_rdata                : combinational read data from memory
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int unsigned       N_MASTERS = 2,
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       MEM_BYTES = 4096,
    parameter int unsigned       WAIT_CYC  = 0
) (
    input  logic                          clk_in,
    input  logic                          reset,
    input  logic [N_MASTERS-1:0]          m_req,
    input  logic [N_MASTERS-1:0]          m_we,
    input  logic [2*N_MASTERS-1:0]        m_size,
    input  logic [N_MASTERS-1:0]          m_sign,
    input  logic [ADDR_W*N_MASTERS-1:0]   m_addr,
    input  logic [DATA_W*N_MASTERS-1:0]   m_wdata,
    output logic [N_MASTERS-1:0]          m_ack,
    output logic [N_MASTERS-1:0]          m_err,
    output logic [DATA_W-1:0]             m_rdata,
    output logic                          mem_w,
    output logic                          mem_r,
    output logic [1:0]                    mem_c,
    output logic                          mem_s,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata
);

    localparam int unsigned       IDX_W    = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam logic [ADDR_W:0]   MemLim   = (ADDR_W + 1)'(MEM_BYTES);
    localparam logic [3:0]        WaitInit = 4'(WAIT_CYC);

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       grant_q, grant_d;
    logic [N_MASTERS-1:0]   gnt_oh_q, gnt_oh_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   we_q, we_d;
    size_e                  size_q, size_d;
    logic                   sign_q, sign_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic                   err_q, err_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic                   mem_w_q, mem_w_d;
    logic                   mem_r_q, mem_r_d;
    logic [N_MASTERS-1:0]   ack_q, ack_d;
    logic [N_MASTERS-1:0]   merr_q, merr_d;

    logic [N_MASTERS-1:0]   arb_grant;
    logic [IDX_W-1:0]       arb_idx;
    logic                   arb_valid;

    logic                   sel_we;
    logic                   sel_sign;
    size_e                  sel_size;
    logic [ADDR_W-1:0]      sel_addr;
    logic [ADDR_W-1:0]      sel_rebased;
    logic [DATA_W-1:0]      sel_wdata;
    logic                   sel_err;

    rr_arbiter #(
        .N     (N_MASTERS),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req_i   (m_req),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    // Fields of the master the arbiter is currently picking, plus its error check.
    always_comb begin
        sel_we      = m_we[arb_idx];
        sel_sign    = m_sign[arb_idx];
        sel_size    = size_e'(m_size[arb_idx*2 +: 2]);
        sel_addr    = m_addr[arb_idx*ADDR_W +: ADDR_W];
        sel_wdata   = m_wdata[arb_idx*DATA_W +: DATA_W];
        // Unsigned subtract: addresses below BASE_ADDR wrap high and fail the range check
        sel_rebased = sel_addr - BASE_ADDR;
        sel_err     = size_align_err(sel_size, sel_addr[1:0]) || ({1'b0, sel_rebased} >= MemLim);
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        gnt_oh_d = gnt_oh_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        size_d   = size_q;
        sign_d   = sign_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        mem_w_d  = 1'b0;
        mem_r_d  = 1'b0;
        ack_d    = '0;
        merr_d   = '0;
        case (state_q)
            StIdle: begin
                if (arb_valid) begin
                    grant_d  = arb_idx;
                    gnt_oh_d = arb_grant;
                    we_d     = sel_we;
                    size_d   = sel_size;
                    sign_d   = sel_sign;
                    addr_d   = sel_rebased;
                    wdata_d  = sel_wdata;
                    err_d    = sel_err;
                    rdata_d  = '0;
                    if (sel_err) begin
                        state_d = StResp;
                    end else begin
                        state_d = StAccess;
                        cnt_d   = WaitInit;
                        mem_w_d = sel_we;
                        mem_r_d = !sel_we;
                    end
                end
            end
            StAccess: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    mem_w_d = we_q;
                    mem_r_d = !we_q;
                end
            end
            StResp: begin
                ack_d   = gnt_oh_q;
                merr_d  = err_q ? gnt_oh_q : '0;
                ptr_d   = (grant_q == IDX_W'(N_MASTERS - 1)) ? '0 : grant_q + 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            gnt_oh_q <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            size_q   <= SZ_BYTE;
            sign_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            mem_w_q  <= 1'b0;
            mem_r_q  <= 1'b0;
            ack_q    <= '0;
            merr_q   <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            gnt_oh_q <= gnt_oh_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            size_q   <= size_d;
            sign_q   <= sign_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            mem_w_q  <= mem_w_d;
            mem_r_q  <= mem_r_d;
            ack_q    <= ack_d;
            merr_q   <= merr_d;
        end
    end

    assign m_ack     = ack_q;
    assign m_err     = merr_q;
    assign m_rdata   = rdata_q;
    assign mem_w     = mem_w_q;
    assign mem_r     = mem_r_q;
    assign mem_c     = size_q;
    assign mem_s     = sign_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench: three masters, BASE_ADDR 0x1000, 4 KiB memory, three wait states.
// Expected responses are queued when a request is driven and compared when its ack appears.
module tb_mem_bus_arbiter;

    localparam logic [31:0] BASE    = 32'h0000_1000;
    localparam int          WAITS   = 3;
    localparam int          LAT_OK  = WAITS + 3;
    localparam int          LAT_ERR = 2;
    localparam int          STROBES = WAITS + 1;

    typedef struct {
        int          m;
        bit          we;
        bit          err;
        logic [1:0]  size;
        bit          sign;
        logic [31:0] maddr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    typedef struct {
        int          lat;
        int          n_r;
        int          n_w;
        bit          stable;
        bit          both;
        bit          got;
        logic [31:0] a0;
        logic [1:0]  c0;
        logic        s0;
        logic [31:0] wd0;
    } obs_t;

    logic        clk;
    logic        rst;
    logic [2:0]  m_req, m_we, m_sign;
    logic [5:0]  m_size;
    logic [95:0] m_addr, m_wdata;
    logic [2:0]  m_ack, m_err;
    logic [31:0] m_rdata;
    logic        mem_w, mem_r, mem_s;
    logic [1:0]  mem_c;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [7:0]  mem [0:4095];
    exp_t        sb [$];
    int          n_checks = 0;
    int          n_errors = 0;

    mem_bus_arbiter #(
        .N_MASTERS (3),
        .ADDR_W    (32),
        .DATA_W    (32),
        .BASE_ADDR (BASE),
        .MEM_BYTES (4096),
        .WAIT_CYC  (WAITS)
    ) dut (
        .clk_in    (clk),
        .reset     (rst),
        .m_req     (m_req),
        .m_we      (m_we),
        .m_size    (m_size),
        .m_sign    (m_sign),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_ack     (m_ack),
        .m_err     (m_err),
        .m_rdata   (m_rdata),
        .mem_w     (mem_w),
        .mem_r     (mem_r),
        .mem_c     (mem_c),
        .mem_s     (mem_s),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Little-endian byte memory with MEM32-style sized, optionally sign-extended reads.
    always_comb begin
        logic [11:0] a;
        a = mem_addr[11:0];
        mem_rdata = '0;
        case (mem_c)
            2'b00: mem_rdata = {{24{mem_s & mem[a][7]}}, mem[a]};
            2'b01: mem_rdata = {{16{mem_s & mem[a + 12'd1][7]}}, mem[a + 12'd1], mem[a]};
            default: mem_rdata = {mem[a + 12'd3], mem[a + 12'd2], mem[a + 12'd1], mem[a]};
        endcase
    end

    always @(posedge clk) begin
        if (mem_w) begin
            mem[mem_addr[11:0]] <= mem_wdata[7:0];
            if (mem_c != 2'b00) mem[mem_addr[11:0] + 12'd1] <= mem_wdata[15:8];
            if (mem_c == 2'b10) begin
                mem[mem_addr[11:0] + 12'd2] <= mem_wdata[23:16];
                mem[mem_addr[11:0] + 12'd3] <= mem_wdata[31:24];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input int m, input bit we, input logic [1:0] size, input bit sign,
                         input logic [31:0] addr, input logic [31:0] wdata, input bit err,
                         input logic [31:0] rdata);
        exp_t e;
        m_we[m]             = we;
        m_size[m*2 +: 2]    = size;
        m_sign[m]           = sign;
        m_addr[m*32 +: 32]  = addr;
        m_wdata[m*32 +: 32] = wdata;
        m_req[m]            = 1'b1;
        e.m = m; e.we = we; e.err = err; e.size = size; e.sign = sign;
        e.maddr = addr - BASE; e.wdata = wdata; e.rdata = rdata;
        e.lat = err ? LAT_ERR : LAT_OK;
        sb.push_back(e);
    endtask

    // Watch negedges until an ack (bounded), recording strobe activity on the way.
    task automatic wait_ack(output obs_t o);
        o = '{lat: 0, n_r: 0, n_w: 0, stable: 1'b1, both: 1'b0, got: 1'b0,
              a0: '0, c0: '0, s0: 1'b0, wd0: '0};
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (mem_r === 1'b1 || mem_w === 1'b1) begin
                if (o.n_r + o.n_w == 0) begin
                    o.a0 = mem_addr; o.c0 = mem_c; o.s0 = mem_s; o.wd0 = mem_wdata;
                end else if (mem_addr !== o.a0 || mem_c !== o.c0 || mem_s !== o.s0 ||
                             mem_wdata !== o.wd0) begin
                    o.stable = 1'b0;
                end
            end
            if (mem_r === 1'b1) o.n_r++;
            if (mem_w === 1'b1) o.n_w++;
            if (mem_r === 1'b1 && mem_w === 1'b1) o.both = 1'b1;
            if (m_ack !== 3'b000) begin
                o.lat = c;
                o.got = 1'b1;
                break;
            end
        end
    endtask

    task automatic collect();
        obs_t       o;
        exp_t       e;
        logic [2:0] oh;
        wait_ack(o);
        check("ack_seen", 64'(o.got), 64'd1);
        if (o.got && sb.size() > 0) begin
            e  = sb.pop_front();
            oh = 3'(1 << e.m);
            check("ack_master", 64'(m_ack), 64'(oh));
            check("err_flag", 64'(m_err), e.err ? 64'(oh) : 64'd0);
            check("rdata", 64'(m_rdata), 64'(e.rdata));
            check("latency", 64'(o.lat), 64'(e.lat));
            check("rd_strobe_cycles", 64'(o.n_r), (!e.err && !e.we) ? 64'(STROBES) : 64'd0);
            check("wr_strobe_cycles", 64'(o.n_w), (!e.err && e.we) ? 64'(STROBES) : 64'd0);
            check("strobes_exclusive", 64'(o.both), 64'd0);
            if (!e.err) begin
                check("mem_addr", 64'(o.a0), 64'(e.maddr));
                check("mem_c", 64'(o.c0), 64'(e.size));
                check("mem_s", 64'(o.s0), 64'(e.sign));
                check("bus_stable", 64'(o.stable), 64'd1);
                check("addr_hold", 64'(mem_addr), 64'(e.maddr));
                if (e.we) check("mem_wdata", 64'(o.wd0), 64'(e.wdata));
            end
        end
    endtask

    task automatic run1(input int m, input bit we, input logic [1:0] size, input bit sign,
                        input logic [31:0] addr, input logic [31:0] wdata, input bit err,
                        input logic [31:0] rdata);
        issue(m, we, size, sign, addr, wdata, err, rdata);
        collect();
        m_req[m] = 1'b0;
        @(negedge clk);
        check("ack_one_cycle", 64'(m_ack), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        m_req = '0; m_we = '0; m_sign = '0; m_size = '0; m_addr = '0; m_wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_ack", 64'(m_ack), 64'd0);
        check("rst_err", 64'(m_err), 64'd0);
        check("rst_rdata", 64'(m_rdata), 64'd0);
        check("rst_mem_w", 64'(mem_w), 64'd0);
        check("rst_mem_r", 64'(mem_r), 64'd0);
        check("rst_mem_c", 64'(mem_c), 64'd0);
        check("rst_mem_s", 64'(mem_s), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);

        // Contention: all three hold req from reset release; expect 0,1,2,0,1,2.
        for (int r = 0; r < 2; r++) begin
            issue(0, 1'b1, 2'b10, 1'b0, 32'h0000_1100, 32'h1111_0000, 1'b0, 32'h0);
            issue(1, 1'b1, 2'b10, 1'b0, 32'h0000_1104, 32'h2222_0000, 1'b0, 32'h0);
            issue(2, 1'b1, 2'b10, 1'b0, 32'h0000_1108, 32'h3333_0000, 1'b0, 32'h0);
            if (r == 0) rst = 1'b0;
            for (int k = 0; k < 3; k++) collect();
        end
        m_req = '0;
        @(negedge clk);

        // Basic data path
        run1(0, 1'b1, 2'b10, 1'b0, 32'h0000_1010, 32'hDEAD_BEEF, 1'b0, 32'h0);
        run1(0, 1'b0, 2'b00, 1'b1, 32'h0000_1013, 32'h0,         1'b0, 32'hFFFF_FFDE);
        run1(0, 1'b0, 2'b01, 1'b0, 32'h0000_1012, 32'h0,         1'b0, 32'h0000_DEAD);
        run1(2, 1'b0, 2'b01, 1'b1, 32'h0000_1012, 32'h0,         1'b0, 32'hFFFF_DEAD);
        run1(1, 1'b0, 2'b10, 1'b0, 32'h0000_1100, 32'h0,         1'b0, 32'h1111_0000);
        run1(2, 1'b1, 2'b00, 1'b0, 32'h0000_1011, 32'h0000_0055, 1'b0, 32'h0);
        run1(0, 1'b0, 2'b10, 1'b0, 32'h0000_1010, 32'h0,         1'b0, 32'hDEAD_55EF);

        // Alignment and reserved size
        run1(0, 1'b0, 2'b01, 1'b0, 32'h0000_1101, 32'h0, 1'b1, 32'h0);
        run1(1, 1'b0, 2'b10, 1'b0, 32'h0000_1102, 32'h0, 1'b1, 32'h0);
        run1(2, 1'b0, 2'b11, 1'b0, 32'h0000_1100, 32'h0, 1'b1, 32'h0);

        // Range edges around BASE_ADDR .. BASE_ADDR+MEM_BYTES
        run1(0, 1'b1, 2'b10, 1'b0, 32'h0000_1FFC, 32'h1234_5678, 1'b0, 32'h0);
        run1(1, 1'b0, 2'b10, 1'b0, 32'h0000_1FFC, 32'h0,         1'b0, 32'h1234_5678);
        run1(1, 1'b0, 2'b10, 1'b0, 32'h0000_2000, 32'h0,         1'b1, 32'h0);
        run1(0, 1'b0, 2'b10, 1'b0, 32'h0000_0FFC, 32'h0,         1'b1, 32'h0);

        // Leave the pointer at 2, then abort a read from master 2 in its second ACCESS cycle.
        run1(1, 1'b0, 2'b10, 1'b0, 32'h0000_1010, 32'h0, 1'b0, 32'hDEAD_55EF);
        m_we[2] = 1'b0; m_size[5:4] = 2'b10; m_sign[2] = 1'b0;
        m_addr[95:64] = 32'h0000_1104; m_req[2] = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_strobe_before", 64'(mem_r), 64'd1);
        rst = 1'b1;
        #1;
        check("abort_mem_r", 64'(mem_r), 64'd0);
        check("abort_mem_w", 64'(mem_w), 64'd0);
        check("abort_ack", 64'(m_ack), 64'd0);
        m_req = '0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("abort_no_ack", 64'(m_ack), 64'd0);
        end
        // Pointer must be back at 0: master 0 wins over master 2.
        issue(0, 1'b0, 2'b10, 1'b0, 32'h0000_1010, 32'h0, 1'b0, 32'hDEAD_55EF);
        issue(2, 1'b0, 2'b10, 1'b0, 32'h0000_1104, 32'h0, 1'b0, 32'h2222_0000);
        rst = 1'b0;
        collect();
        m_req[0] = 1'b0;
        collect();
        m_req = '0;
        @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Parametrised successor to the single-CPU/single-memory hookup in the top-level dataflow wrapper.
- Arbitrates N masters (CPU instruction fetch, CPU data, DMA, ...) onto one MEM32-style unified memory port.
- Adds round-robin arbitration, configurable wait states, base-address rebasing, and alignment/range error reporting.
- Sits between the cpu instances and the memory in the top level; the size code and sign flag pass through unchanged to memory.

Parameters:
- N_MASTERS, 2, number of requesting channels (1..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width (fixed byte lanes of 8).
- BASE_ADDR, 32'h0000_0000, subtracted from master address to form the memory address.
- MEM_BYTES, 4096, memory size in bytes; rebased address >= MEM_BYTES is out of range.
- WAIT_CYC, 0, extra cycles the memory strobe is held (0..15).

Ports:
- clk_in  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- m_req  in  N_MASTERS  per-master request, held until ack.
- m_we  in  N_MASTERS  1 = write, 0 = read.
- m_size  in  2*N_MASTERS  00 byte, 01 half, 10 word, 11 reserved.
- m_sign  in  N_MASTERS  sign-extend on read.
- m_addr  in  ADDR_W*N_MASTERS  byte address.
- m_wdata  in  DATA_W*N_MASTERS  write data.
- m_ack  out  N_MASTERS  one-cycle completion pulse.
- m_err  out  N_MASTERS  valid with m_ack: misaligned, out of range, or reserved size.
- m_rdata  out  DATA_W  read data, valid with m_ack; shared by all masters.
- mem_w  out  1  memory write strobe.
- mem_r  out  1  memory read strobe.
- mem_c  out  2  size code to memory.
- mem_s  out  1  sign flag to memory.
- mem_addr  out  ADDR_W  rebased address.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  combinational read data from memory.

Behaviour:
- Reset, asynchronous: all outputs 0; FSM in IDLE; RR pointer 0; wait counter 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any m_req is set, grant the first requester at or after the RR pointer, scanning upward with wrap.
  - Latch that master's we/size/sign/addr/wdata into internal registers.
  - Check the latched request:
    - size 11 -> error.
    - half with addr[0] != 0 -> error.
    - word with addr[1:0] != 0 -> error.
    - (addr - BASE_ADDR) >= MEM_BYTES, unsigned subtraction, so an address below BASE wraps and is out of range -> error.
  - Error: go to RESP with err=1 and no memory strobe.
  - Otherwise go to ACCESS; counter = WAIT_CYC.
- ACCESS:
  - mem_w or mem_r is asserted from the latched registers.
  - mem_addr, mem_c, mem_s and mem_wdata are stable from the latched registers for the whole state.
  - The state lasts WAIT_CYC+1 cycles.
  - On the last cycle, capture mem_rdata into the rdata register (reads only) and go to RESP.
- RESP:
  - m_ack[grant] = 1 and m_err[grant] = err for exactly one cycle.
  - m_rdata holds the captured value; it is 0 on writes and errors.
  - RR pointer = grant+1 mod N_MASTERS.
  - Return to IDLE.
- Latency: req sampled high in IDLE -> ack pulse WAIT_CYC+3 cycles after that edge (error: 2 cycles).
  - IDLE and RESP each cost one cycle, so back-to-back throughput is one access per WAIT_CYC+3 cycles.
- Deasserting m_req mid-access has no effect: the transaction completes and ack still pulses.
- A master whose req stays high after ack is re-arbitrated, so it loses to other waiting masters under RR.
- Strobes are 0 outside ACCESS; mem_w and mem_r are never both 1.
- mem_addr, mem_c, mem_s and mem_wdata also hold their last values outside ACCESS; only the strobes return to 0.
- Reset mid-access: strobes drop immediately; no ack is issued for the aborted transaction.

Decomposition:
- Package mem_bus_pkg holds:
  - size codes SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD;
  - FSM state encodings;
  - the alignment-check function.
- One sub-module, rr_arbiter: req vector plus pointer in -> one-hot grant and index out, purely combinational.

Test Plan:
- Single master, WAIT_CYC=0: word write 32'hDEADBEEF to 0x10, then signed byte read at 0x13 -> mem_w one cycle with addr 0x10, c=10; the read returns 32'hFFFFFFDE from the memory model; each ack 3 cycles after req.
- Contention, N=3, all req held from reset release -> grant order 0,1,2,0,...; no master is granted twice while another waits.
- Alignment: half read at 0x101 and word at 0x102 -> err=1 ack at 2 cycles, mem_r never asserted; size 11 -> err.
- Range, BASE_ADDR=0x1000, MEM_BYTES=4096:
  - addr 0x1FFC word -> ok, mem_addr 0xFFC.
  - addr 0x2000 -> err.
  - addr 0x0FFC -> err (wrap).
- WAIT_CYC=3: read -> mem_r high exactly 4 cycles with constant mem_addr; ack at cycle 6.
- Reset asserted during ACCESS cycle 2 -> strobes 0 the same cycle, no ack, pointer 0; a new request after release completes normally.
